// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters,
// with a one-entry registered response buffer tagged by requester ID.
module alu_share_arbiter #(
    parameter int MAX_LENGTH = 32,
    parameter int FUNC_SIZE  = 4,
    parameter int NOP_CMD    = 0,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  r0_valid,
    output logic                  r0_ready,
    input  logic [FUNC_SIZE-1:0]  r0_cmd,
    input  logic [MAX_LENGTH-1:0] r0_a,
    input  logic [MAX_LENGTH-1:0] r0_b,
    input  logic                  r1_valid,
    output logic                  r1_ready,
    input  logic [FUNC_SIZE-1:0]  r1_cmd,
    input  logic [MAX_LENGTH-1:0] r1_a,
    input  logic [MAX_LENGTH-1:0] r1_b,
    output logic [MAX_LENGTH-1:0] alu_valuein1,
    output logic [MAX_LENGTH-1:0] alu_valuein2,
    output logic [FUNC_SIZE-1:0]  alu_exe_cmd,
    input  logic [MAX_LENGTH-1:0] alu_result,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [MAX_LENGTH-1:0] rsp_data,
    output logic [CNT_W-1:0]      op_count
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t state;
    state_t next_state;
    logic   last_grant;
    logic   can_accept;
    logic   grant_valid;
    logic   grant_id;

    assign can_accept = (state == EMPTY) || rsp_ready;
    assign rsp_valid  = (state == FULL);

    // On a tie the requester that was not served last wins; readys stay low in reset.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        if (rst_n && can_accept) begin
            if (r0_valid && r1_valid) begin
                grant_valid = 1'b1;
                grant_id    = ~last_grant;
            end else if (r0_valid) begin
                grant_valid = 1'b1;
            end else if (r1_valid) begin
                grant_valid = 1'b1;
                grant_id    = 1'b1;
            end
        end
    end

    assign r0_ready = grant_valid && !grant_id;
    assign r1_ready = grant_valid && grant_id;

    always_comb begin
        alu_exe_cmd  = FUNC_SIZE'(NOP_CMD);
        alu_valuein1 = '0;
        alu_valuein2 = '0;
        if (grant_valid) begin
            alu_exe_cmd  = grant_id ? r1_cmd : r0_cmd;
            alu_valuein1 = grant_id ? r1_a : r0_a;
            alu_valuein2 = grant_id ? r1_b : r0_b;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            EMPTY: if (grant_valid) next_state = FULL;
            FULL:  if (rsp_ready && !grant_valid) next_state = EMPTY;
            default: next_state = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            rsp_id     <= 1'b0;
            rsp_data   <= '0;
            last_grant <= 1'b1;
            op_count   <= '0;
        end else begin
            state <= next_state;
            if (grant_valid) begin
                rsp_data   <= alu_result;
                rsp_id     <= grant_id;
                last_grant <= grant_id;
                if (op_count != {CNT_W{1'b1}}) begin
                    op_count <= op_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized scoreboard bench for alu_share_arbiter; a behavioural ALU model
// drives alu_result and a least-recently-served model predicts every grant.
module tb_alu_share_arbiter;

    localparam logic [3:0] ADD_CMD = 4'd1;
    localparam logic [3:0] SUB_CMD = 4'd2;

    logic        clk;
    logic        rst_n;
    logic        r0_valid, r1_valid;
    logic        r0_ready, r1_ready;
    logic [3:0]  r0_cmd, r1_cmd;
    logic [31:0] r0_a, r0_b, r1_a, r1_b;
    logic [31:0] alu_valuein1, alu_valuein2, alu_result;
    logic [3:0]  alu_exe_cmd;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_data;
    logic [15:0] op_count;

    int n_checks;
    int n_pass;
    int timeouts;
    int seen_timeouts;
    logic r0_acc, r1_acc;

    logic        m_full;
    logic [15:0] m_cnt;
    logic        order [2];
    logic [32:0] sb [$];
    logic        hold_v;
    logic [32:0] hold_val;

    alu_share_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_cmd(r0_cmd), .r0_a(r0_a), .r0_b(r0_b),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_cmd(r1_cmd), .r1_a(r1_a), .r1_b(r1_b),
        .alu_valuein1(alu_valuein1), .alu_valuein2(alu_valuein2), .alu_exe_cmd(alu_exe_cmd),
        .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .op_count(op_count)
    );

    function automatic logic [31:0] alu_ref(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
        case (cmd)
            ADD_CMD: return a + b;
            SUB_CMD: return a - b;
            default: return 32'd0;
        endcase
    endfunction

    assign alu_result = alu_ref(alu_exe_cmd, alu_valuein1, alu_valuein2);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Monitor/scoreboard: predicts grants from a least-recently-served order and
    // compares every consumed response against the queued expectation.
    always @(negedge clk) begin
        logic        want [2];
        logic        ev;
        logic        eid;
        logic [3:0]  ecmd;
        logic [31:0] ea, eb;
        logic [32:0] head;
        if (timeouts != seen_timeouts) begin
            check_output(1'b0, "handshake_timeout", 64'(timeouts), 64'(seen_timeouts));
            seen_timeouts = timeouts;
        end
        if (!rst_n) begin
            check_output(rsp_valid == 1'b0, "reset_rsp_valid", 64'(rsp_valid), 64'd0);
            check_output(op_count == 16'd0, "reset_op_count", 64'(op_count), 64'd0);
            check_output({r1_ready, r0_ready} == 2'b00, "reset_readys", 64'({r1_ready, r0_ready}), 64'd0);
            m_full = 1'b0;
            m_cnt = '0;
            order[0] = 1'b0;
            order[1] = 1'b1;
            sb.delete();
            hold_v = 1'b0;
            r0_acc = 1'b0;
            r1_acc = 1'b0;
        end else begin
            want[0] = r0_valid;
            want[1] = r1_valid;
            ev = 1'b0;
            eid = 1'b0;
            if (!m_full || rsp_ready) begin
                if (want[order[0]]) begin ev = 1'b1; eid = order[0]; end
                else if (want[order[1]]) begin ev = 1'b1; eid = order[1]; end
            end
            ecmd = 4'd0; ea = '0; eb = '0;
            if (ev) begin
                ecmd = eid ? r1_cmd : r0_cmd;
                ea   = eid ? r1_a : r0_a;
                eb   = eid ? r1_b : r0_b;
            end
            check_output({r1_ready, r0_ready} == {ev && eid, ev && !eid}, "grant",
                         64'({r1_ready, r0_ready}), 64'({ev && eid, ev && !eid}));
            check_output({alu_exe_cmd, alu_valuein1, alu_valuein2} == {ecmd, ea, eb}, "alu_drive",
                         64'({alu_exe_cmd, alu_valuein1}), 64'({ecmd, ea}));
            check_output(rsp_valid == m_full, "rsp_valid", 64'(rsp_valid), 64'(m_full));
            check_output(op_count == m_cnt, "op_count", 64'(op_count), 64'(m_cnt));
            if (hold_v) begin
                check_output({rsp_id, rsp_data} == hold_val, "rsp_hold", 64'({rsp_id, rsp_data}), 64'(hold_val));
            end
            hold_v = rsp_valid && !rsp_ready;
            hold_val = {rsp_id, rsp_data};
            if (m_full && rsp_ready) begin
                if (sb.size() == 0) begin
                    check_output(1'b0, "sb_underflow", 64'd0, 64'd1);
                end else begin
                    head = sb.pop_front();
                    check_output(rsp_id == head[32], "rsp_id", 64'(rsp_id), 64'(head[32]));
                    check_output(rsp_data == head[31:0], "rsp_data", 64'(rsp_data), 64'(head[31:0]));
                end
            end
            if (ev) begin
                sb.push_back({eid, alu_ref(ecmd, ea, eb)});
                m_full = 1'b1;
                if (order[0] == eid) begin
                    order[0] = order[1];
                    order[1] = eid;
                end
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end else if (rsp_ready) begin
                m_full = 1'b0;
            end
            r0_acc = r0_valid && r0_ready;
            r1_acc = r1_valid && r1_ready;
        end
    end

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 3))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // One cycle of stimulus: a requester only changes its request after acceptance.
    task automatic apply_stimulus(input int p_valid, input int p_ready);
        if (!r0_valid || r0_acc) begin
            r0_valid = ($urandom_range(0, 99) < p_valid);
            r0_cmd = 4'($urandom_range(0, 3));
            r0_a = rand_word();
            r0_b = rand_word();
        end
        if (!r1_valid || r1_acc) begin
            r1_valid = ($urandom_range(0, 99) < p_valid);
            r1_cmd = 4'($urandom_range(0, 3));
            r1_a = rand_word();
            r1_b = rand_word();
        end
        rsp_ready = ($urandom_range(0, 99) < p_ready);
        @(posedge clk);
        #1;
    endtask

    task automatic send_one(input bit id, input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
        bit done;
        rsp_ready = 1'b1;
        if (id) begin r1_valid = 1'b1; r1_cmd = cmd; r1_a = a; r1_b = b; end
        else    begin r0_valid = 1'b1; r0_cmd = cmd; r0_a = a; r0_b = b; end
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(posedge clk);
            #1;
            if (id ? r1_acc : r0_acc) done = 1'b1;
        end
        if (!done) timeouts++;
        if (id) r1_valid = 1'b0;
        else    r0_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0; n_pass = 0; timeouts = 0; seen_timeouts = 0;
        rst_n = 1'b0;
        r0_valid = 1'b0; r0_cmd = '0; r0_a = '0; r0_b = '0;
        r1_valid = 1'b0; r1_cmd = '0; r1_a = '0; r1_b = '0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        send_one(1'b0, ADD_CMD, 32'd5, 32'd7);
        send_one(1'b1, SUB_CMD, 32'd3, 32'd5);
        send_one(1'b0, ADD_CMD, 32'hFFFF_FFFF, 32'd1);
        @(posedge clk);
        #1;

        pulse_reset();
        repeat (6) apply_stimulus(100, 100);
        repeat (4) apply_stimulus(100, 0);
        repeat (6) apply_stimulus(100, 100);

        apply_stimulus(100, 0);
        #2;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) apply_stimulus(100, 100);

        repeat (10) apply_stimulus(0, 100);
        repeat (3) @(posedge clk);
        #1;
        send_one(1'b0, 4'hF, 32'd9, 32'd9);
        repeat (3) @(posedge clk);
        #1;

        repeat (400) apply_stimulus(70, 70);
        repeat (10) apply_stimulus(0, 100);
        @(posedge clk);
        #1;

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
